// File: rtl/send_lane_scheduler_if.sv
// Transmit stream from the send-lane scheduler to the RDMA engine.
// Latency: none, wires only.
// Backpressure: txReady from the slave stalls the master, which holds txData/txLast/txLane.
// Ports: txData/txValid/txLast/txLane driven by the master, txReady driven by the slave.
interface send_lane_scheduler_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 256
) ();
  localparam int IDX_W = $clog2(LANES);

  logic [DATA_W-1:0] txData;
  logic              txValid;
  logic              txReady;
  logic              txLast;
  logic [IDX_W-1:0]  txLane;

  modport master (
    output txData,
    output txValid,
    output txLast,
    output txLane,
    input  txReady
  );

  modport slave (
    input  txData,
    input  txValid,
    input  txLast,
    input  txLane,
    output txReady
  );
endinterface

// File: rtl/send_lane_scheduler.sv
// Round-robin drain of the send-buffer lanes into the RDMA transmit stream, bounded bursts.
// Latency: eligible lane in an IDLE cycle -> txValid the next cycle; one idle cycle between bursts.
// Backpressure: txReady low holds the current beat and suppresses lanePop; valid never drops mid-beat.
// Ports: clock/reset, enable, burstLen; lane side laneEmpty/laneLevel/laneData in, lanePop out;
//        tx stream via interface (master); busy and burstCount status out.
module send_lane_scheduler #(
  parameter int LANES  = 4,
  parameter int DATA_W = 256,
  parameter int LVL_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3:0]              burstLen,
  input  logic [LANES-1:0]        laneEmpty,
  input  logic [LANES*LVL_W-1:0]  laneLevel,
  input  logic [LANES*DATA_W-1:0] laneData,
  output logic [LANES-1:0]        lanePop,
  output logic                    busy,
  output logic [15:0]             burstCount,
  send_lane_scheduler_if.master   tx
);
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] lastGrant, lastGrant_nxt;
  logic [3:0]       remaining, remaining_nxt;
  logic [15:0]      burstCount_nxt;

  logic [LANES-1:0] eligible;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic [3:0]       effBurst;
  logic [LVL_W-1:0] pickLevel;
  logic [3:0]       loadLen;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      eligible[i] = !laneEmpty[i] && (laneLevel[i*LVL_W +: LVL_W] != '0);
    end
  end

  // Rotating priority: offsets 1..LANES from lastGrant, so the last granted
  // lane is considered only after every other lane.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= LANES; k++) begin
      idx = lastGrant + IDX_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Burst length is frozen at grant: min(effective burstLen, level of picked lane).
  always_comb begin
    effBurst  = ((burstLen == 4'd0) || (burstLen > 4'd8)) ? 4'd8 : burstLen;
    pickLevel = laneLevel[int'(pick)*LVL_W +: LVL_W];
    if (32'(pickLevel) < 32'(effBurst)) begin
      loadLen = 4'(pickLevel);
    end else begin
      loadLen = effBurst;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    lastGrant_nxt  = lastGrant;
    remaining_nxt  = remaining;
    burstCount_nxt = burstCount;
    lanePop        = '0;
    busy           = 1'b0;
    tx.txValid     = 1'b0;
    tx.txLast      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_nxt     = SEND;
          grant_nxt     = pick;
          lastGrant_nxt = pick;
          remaining_nxt = loadLen;
        end
      end
      SEND: begin
        // Occupancy was checked at grant and lanes only grow, so valid is unconditional.
        busy       = 1'b1;
        tx.txValid = 1'b1;
        tx.txLast  = (remaining == 4'd1);
        if (tx.txReady) begin
          lanePop[grant] = 1'b1;
          remaining_nxt  = remaining - 4'd1;
          if (remaining == 4'd1) begin
            state_nxt      = IDLE;
            burstCount_nxt = burstCount + 16'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head data of the granted lane; the lane FIFO advances its head after each pop.
  assign tx.txData = laneData[int'(grant)*DATA_W +: DATA_W];
  assign tx.txLane = grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      lastGrant  <= IDX_W'(LANES - 1);
      remaining  <= '0;
      burstCount <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      lastGrant  <= lastGrant_nxt;
      remaining  <= remaining_nxt;
      burstCount <= burstCount_nxt;
    end
  end
endmodule

// File: doc/send_lane_scheduler.md
# send_lane_scheduler

Round-robin drain scheduler for the four-lane 256-bit send buffer. It watches per-lane occupancy and grants one lane at a time. It moves a bounded burst of beats from that lane to the RDMA engine over a valid/ready stream, framing each burst with a last flag, and drives the per-lane pop strobes. It sits between the send buffer's lane FIFOs (show-ahead, 8 deep) and the RDMA transmit path.

## Interface
Parameters:
- LANES, 4, number of buffer lanes (power of two, ≥2)
- DATA_W, 256, beat width
- LVL_W, 4, width of per-lane occupancy (FIFO depth 8 → 0..8)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- enable  in  1  permits new grants
- burstLen  in  4  max beats per burst; 0 means 8, values >8 saturate to 8
- laneEmpty  in  LANES  per-lane FIFO empty
- laneLevel  in  LANES*LVL_W  per-lane occupancy, lane i at [i*LVL_W +: LVL_W]
- laneData  in  LANES*DATA_W  per-lane show-ahead head data
- lanePop  out  LANES  one-hot pop strobe, one cycle per accepted beat
- txData  out  DATA_W  beat to RDMA
- txValid  out  1  beat valid
- txReady  in  1  RDMA accepts beat
- txLast  out  1  final beat of burst
- txLane  out  2  lane index of current burst (log2 LANES)
- busy  out  1  burst in progress
- burstCount  out  16  completed bursts, wraps

## Operation
- Only this block pops the lanes. Producers only push, so a lane's level never drops below its value at grant during a burst.
- Lane i is eligible when laneEmpty[i]=0 and level[i]≠0.
- FSM states:
  - IDLE → SEND: when enable=1 and any lane is eligible. Grant the first eligible lane searching from lastGrant+1 modulo LANES. Register grant and lastGrant. Load remaining = min(effBurstLen, level[grant]), where effBurstLen = (burstLen==0 || burstLen>8) ? 8 : burstLen.
  - SEND → IDLE: on the handshake (txValid & txReady) with remaining==1. Increment burstCount (16-bit wrap).
  - SEND otherwise: each handshake decrements remaining and pulses lanePop[grant].
- Outputs in SEND:
  - txValid=1, because occupancy is guaranteed.
  - txData = laneData[grant] (combinational mux from registered grant).
  - txLane = grant; txLast = (remaining==1); busy=1.
- Outputs in IDLE: txValid=0, txLast=0, lanePop=0, busy=0. txData and txLane hold the last grant's values and are don't-care.
- lanePop = (state==SEND & txReady) one-hot on grant. It is never asserted for a non-granted lane or in IDLE.
- Arithmetic:
  - remaining is 4 bits, range 1..8, never 0 in SEND.
  - min() is an unsigned compare.
  - burstLen and laneLevel are sampled only at grant; changes mid-burst are ignored.
- enable deasserted mid-burst: the current burst completes, then no new grant until enable=1.
- txReady low: hold txData, txLast and remaining stable, and issue no pop (AXI-style; valid never drops once raised until handshake).
- Reset: state=IDLE, lastGrant=LANES-1 (so lane 0 wins first), remaining=0, burstCount=0, all outputs 0. Reset mid-burst abandons the burst with no further pops; unsent beats stay in the FIFO.

## Timing
- Grant latency: eligibility seen in cycle N (IDLE) → txValid=1 in N+1.
- Throughput: one beat per cycle while txReady=1.
- Exactly one idle cycle between consecutive bursts, because IDLE re-arbitrates.
- A burst of k beats with txReady held high occupies k SEND cycles plus 1 IDLE cycle.
- lanePop is asserted in the same cycle as the handshake. The FIFO updates its head on the next edge, so laneData[grant] is valid for the next beat in the following cycle.
- burstCount updates on the edge after the txLast handshake.

## Test plan
- Reset then idle: all lanes empty, enable=1 → txValid=0, lanePop=0, burstCount=0 for 20 cycles.
- Single lane: lane 2 level=5, burstLen=8, txReady=1 → 5 beats on txLane=2, txLast on beat 5, lanePop=4'b0100 five cycles, burstCount=1.
- Round-robin fairness: all lanes level 8, burstLen=3 → grant order 0,1,2,3,0…, 3 beats each, one bubble between bursts, burstCount=8 after two rounds.
- Backpressure: lane 1 level=4, txReady toggled 1,0,0,1,1,0,1 → data and txLast stable while stalled, exactly 4 pops, no pop while txReady=0.
- Config edges: burstLen=0 and burstLen=12 with level 8 → 8-beat bursts. Level rises from 2 to 6 mid-burst → burst still 2 beats.
- Enable/reset mid-burst: deassert enable on beat 2 of 6 → burst finishes, no new grant. Repeat with reset=1 on beat 2 → next cycle txValid=0, busy=0, burstCount=0, no pop, lane 0 granted first after release.
